stack_calc_engine: RTL and testbench

- Multi-channel, multi-bit successor to the two-stack single-bit calculation datapath.
- NCH independent LIFO stacks, each DEPTH entries of WIDTH bits.
- Driven by a valid/ready command stream; returns one response per command with 1-cycle latency.
- Adds occupancy tracking, overflow/underflow detection, binary LUT reduction and response backpressure, none of which the previous generation had.

---
 rtl/stack_calc_engine_pkg.sv | 22 ++
 rtl/stack_calc_engine_channel.sv | 66 ++++++
 rtl/stack_calc_engine.sv | 196 +++++++++++++++++++
 tb/tb_stack_calc_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_calc_engine_pkg.sv
// Shared definitions for the stack calculation engine: opcode encoding and
// the two-input truth-table evaluator used by LUT and LUT_POP.
package calc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_WRITE   = 3'd3,
    OP_LUT     = 3'd4,
    OP_LUT_POP = 3'd5,
    OP_CLEAR   = 3'd6
  } calc_op_t;

  // Evaluate a 2-input truth table; index is {a,b}.
  function automatic logic lut2(input logic [3:0] lut, input logic a, input logic b);
    return lut[{a, b}];
  endfunction

endpackage

// File: rtl/stack_calc_engine_channel.sv
// One LIFO stack: DEPTH x WIDTH shift storage (entry 0 is the top) plus its
// occupancy counter. Entries at or below the occupancy are always zero, so a
// pop shifts a zero in from the bottom and an empty stack reads top=0.
// With STACK_CALC_DBG_EN defined, a flat view of the storage is exported.
module stack_channel
  import calc_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty
`ifdef STACK_CALC_DBG_EN
  ,output logic [DEPTH*WIDTH-1:0] view
`endif
);

  logic [WIDTH-1:0] ent [DEPTH];
  logic [CNT_W-1:0] cnt;

  // Storage and occupancy update; clear wins, pop may also rewrite the new top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
      cnt <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
      cnt <= '0;
    end else if (push) begin
      ent[0] <= wr_data;
      for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
      cnt <= cnt + CNT_W'(1);
    end else if (pop) begin
      for (int k = 0; k < DEPTH - 1; k++) ent[k] <= ent[k+1];
      ent[DEPTH-1] <= '0;
      if (wr) ent[0] <= wr_data;
      cnt <= cnt - CNT_W'(1);
    end else if (wr) begin
      ent[0] <= wr_data;
    end
  end

  assign top    = ent[0];
  assign second = ent[1];
  assign depth  = cnt;
  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);

`ifdef STACK_CALC_DBG_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    assign view[k*WIDTH +: WIDTH] = ent[k];
  end
`endif

endmodule

// File: rtl/stack_calc_engine.sv
// stack_calc_engine: NCH independent LIFO stacks driven by a valid/ready
// command stream, one registered response per command (1-cycle latency).
// Optional macro STACK_CALC_DBG_EN exports every stack entry on db_stacks.
module stack_calc_engine
  import calc_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int WIDTH = 1,
  parameter int NCH   = 2,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [WIDTH-1:0] cmd_val,
  input  logic [3:0]       cmd_lut,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CH_W-1:0]  rsp_ch,
  output logic [WIDTH-1:0] rsp_top,
  output logic [CNT_W-1:0] rsp_depth,
  output logic             rsp_err,
  output logic [NCH-1:0]   err_sticky
`ifdef STACK_CALC_DBG_EN
  ,output logic [NCH*DEPTH*WIDTH-1:0] db_stacks
`endif
);

  logic [WIDTH-1:0] ch_top   [NCH];
  logic [WIDTH-1:0] ch_sec   [NCH];
  logic [CNT_W-1:0] ch_depth [NCH];
  logic [NCH-1:0]   ch_full, ch_empty;
  logic [NCH-1:0]   push_v, pop_v, wr_v, clr_v;

  logic             accept, ch_ok, op_err;
  logic             do_push, do_pop, do_wr, do_clr;
  logic [WIDTH-1:0] cur_top, cur_sec, wr_data, nxt_top;
  logic [WIDTH-1:0] lut_res, lutpop_res;
  logic [CNT_W-1:0] cur_d, nxt_d;
  logic             cur_full, cur_empty;

  assign cmd_ready = ~rsp_valid | rsp_ready;
  assign accept    = cmd_valid & cmd_ready;

  // Select the addressed channel, check preconditions and form the response.
  always_comb begin
    ch_ok     = (int'(cmd_ch) < NCH);
    cur_top   = '0;
    cur_sec   = '0;
    cur_d     = '0;
    cur_full  = 1'b0;
    cur_empty = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (int'(cmd_ch) == c) begin
        cur_top   = ch_top[c];
        cur_sec   = ch_sec[c];
        cur_d     = ch_depth[c];
        cur_full  = ch_full[c];
        cur_empty = ch_empty[c];
      end
    end

    lut_res    = '0;
    lutpop_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lut_res[i]    = lut2(cmd_lut, cmd_val[i], cur_top[i]);
      lutpop_res[i] = lut2(cmd_lut, cur_top[i], cur_sec[i]);
    end

    op_err  = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_wr   = 1'b0;
    do_clr  = 1'b0;
    wr_data = cmd_val;
    nxt_top = cur_top;
    nxt_d   = cur_d;

    case (cmd_op)
      OP_NOP: ;
      OP_PUSH: begin
        op_err  = cur_full;
        do_push = 1'b1;
        nxt_top = cmd_val;
        nxt_d   = cur_d + CNT_W'(1);
      end
      OP_POP: begin
        op_err  = cur_empty;
        do_pop  = 1'b1;
        nxt_top = cur_sec;
        nxt_d   = cur_d - CNT_W'(1);
      end
      OP_WRITE: begin
        op_err  = cur_empty;
        do_wr   = 1'b1;
        nxt_top = cmd_val;
      end
      OP_LUT: begin
        op_err  = cur_empty;
        do_wr   = 1'b1;
        wr_data = lut_res;
        nxt_top = lut_res;
      end
      OP_LUT_POP: begin
        op_err  = (cur_d < CNT_W'(2));
        do_pop  = 1'b1;
        do_wr   = 1'b1;
        wr_data = lutpop_res;
        nxt_top = lutpop_res;
        nxt_d   = cur_d - CNT_W'(1);
      end
      OP_CLEAR: begin
        do_clr  = 1'b1;
        nxt_top = '0;
        nxt_d   = '0;
      end
      default: op_err = 1'b1;
    endcase

    if (!ch_ok) op_err = 1'b1;

    // A rejected command leaves the stack untouched and reports its current view.
    if (op_err) begin
      do_push = 1'b0;
      do_pop  = 1'b0;
      do_wr   = 1'b0;
      do_clr  = 1'b0;
      nxt_top = cur_top;
      nxt_d   = cur_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic sel;
    assign sel      = accept && (cmd_ch == CH_W'(c));
    assign push_v[c] = sel & do_push;
    assign pop_v[c]  = sel & do_pop;
    assign wr_v[c]   = sel & do_wr;
    assign clr_v[c]  = sel & do_clr;

    stack_channel #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_stack (
      .clk     (clk),
      .reset   (reset),
      .push    (push_v[c]),
      .pop     (pop_v[c]),
      .wr      (wr_v[c]),
      .wr_data (wr_data),
      .clr     (clr_v[c]),
      .top     (ch_top[c]),
      .second  (ch_sec[c]),
      .depth   (ch_depth[c]),
      .full    (ch_full[c]),
      .empty   (ch_empty[c])
`ifdef STACK_CALC_DBG_EN
      ,.view   (db_stacks[c*DEPTH*WIDTH +: DEPTH*WIDTH])
`endif
    );
  end

  // Response register (held until drained) and per-channel sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid  <= 1'b0;
      rsp_ch     <= '0;
      rsp_top    <= '0;
      rsp_depth  <= '0;
      rsp_err    <= 1'b0;
      err_sticky <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_ch    <= cmd_ch;
        rsp_top   <= nxt_top;
        rsp_depth <= nxt_d;
        rsp_err   <= op_err;
        for (int c = 0; c < NCH; c++) begin
          if (ch_ok && int'(cmd_ch) == c) begin
            if (do_clr)      err_sticky[c] <= 1'b0;
            else if (op_err) err_sticky[c] <= 1'b1;
          end
        end
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stack_calc_engine.sv
// Randomised scoreboard bench for stack_calc_engine with a queue-based model.
module tb_stack_calc_engine;
  import calc_pkg::*;

  localparam int DEPTH = 6;
  localparam int WIDTH = 1;
  localparam int NCH   = 2;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [CH_W-1:0]  cmd_ch = '0;
  logic [WIDTH-1:0] cmd_val = '0;
  logic [3:0]       cmd_lut = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [CH_W-1:0]  rsp_ch;
  logic [WIDTH-1:0] rsp_top;
  logic [CNT_W-1:0] rsp_depth;
  logic             rsp_err;
  logic [NCH-1:0]   err_sticky;
`ifdef STACK_CALC_DBG_EN
  logic [NCH*DEPTH*WIDTH-1:0] db_stacks;
`endif

  stack_calc_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_ch     (cmd_ch),
    .cmd_val    (cmd_val),
    .cmd_lut    (cmd_lut),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_ch     (rsp_ch),
    .rsp_top    (rsp_top),
    .rsp_depth  (rsp_depth),
    .rsp_err    (rsp_err),
    .err_sticky (err_sticky)
`ifdef STACK_CALC_DBG_EN
    ,.db_stacks (db_stacks)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] depth;
    logic             err;
    logic [NCH-1:0]   sticky;
  } rsp_t;

  rsp_t             exp_q [$];
  logic [WIDTH-1:0] stk [NCH][$];
  logic [NCH-1:0]   m_sticky = '0;

  int  vectors = 0;
  int  miscompares = 0;
  bit  rdy_force = 1'b1;
  bit  rdy_val = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stacks as queues, front = top.
  function automatic rsp_t model_step(input int op, input int ch,
                                      input logic [WIDTH-1:0] val, input logic [3:0] lut);
    rsp_t r;
    bit err;
    logic [WIDTH-1:0] a, b, t;
    err = 1'b0;
    if (ch >= NCH) err = 1'b1;
    else begin
      case (op)
        0: ;
        1: if (stk[ch].size() >= DEPTH) err = 1'b1; else stk[ch].push_front(val);
        2: if (stk[ch].size() < 1) err = 1'b1; else a = stk[ch].pop_front();
        3: if (stk[ch].size() < 1) err = 1'b1; else stk[ch][0] = val;
        4: if (stk[ch].size() < 1) err = 1'b1;
           else begin
             a = stk[ch][0];
             for (int i = 0; i < WIDTH; i++) t[i] = lut[{val[i], a[i]}];
             stk[ch][0] = t;
           end
        5: if (stk[ch].size() < 2) err = 1'b1;
           else begin
             a = stk[ch].pop_front();
             b = stk[ch].pop_front();
             for (int i = 0; i < WIDTH; i++) t[i] = lut[{a[i], b[i]}];
             stk[ch].push_front(t);
           end
        6: begin stk[ch].delete(); m_sticky[ch] = 1'b0; end
        default: err = 1'b1;
      endcase
      if (err) m_sticky[ch] = 1'b1;
    end
    r.ch     = ch[CH_W-1:0];
    r.err    = err;
    r.depth  = (ch < NCH) ? CNT_W'(stk[ch].size()) : '0;
    r.top    = (ch < NCH && stk[ch].size() > 0) ? stk[ch][0] : '0;
    r.sticky = m_sticky;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the command was accepted.
  task automatic send(input int op, input int ch, input logic [WIDTH-1:0] val, input logic [3:0] lut);
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op[2:0];
    cmd_ch    = ch[CH_W-1:0];
    cmd_val   = val;
    cmd_lut   = lut;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back(model_step(op, ch, val, lut));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_ready(input bit force_en, input bit val);
    @(negedge clk);
    rdy_force = force_en;
    rdy_val   = val;
    @(posedge clk); #1;
  endtask

  // Response-ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      rsp_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: handshake rule, hold stability and scoreboard compare.
  initial begin
    bit   hold_prev;
    rsp_t prev, act, e;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_prev = 1'b0;
      end else begin
        act = '{ch: rsp_ch, top: rsp_top, depth: rsp_depth, err: rsp_err, sticky: err_sticky};
        chk("cmd_ready", cmd_ready, !rsp_valid || rsp_ready);
        if (hold_prev) begin
          chk("hold_valid", rsp_valid, 1'b1);
          chk("hold_rsp", act, prev);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_ch", act.ch, e.ch);
            chk("rsp_top", act.top, e.top);
            chk("rsp_depth", act.depth, e.depth);
            chk("rsp_err", act.err, e.err);
            chk("err_sticky", act.sticky, e.sticky);
          end
        end
        hold_prev = rsp_valid && !rsp_ready;
        prev = act;
      end
    end
  end

  initial begin
    bit drained;
    // Reset state
    #12;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_depth", rsp_depth, '0);
    chk("rst_sticky", err_sticky, '0);
`ifdef STACK_CALC_DBG_EN
    chk("rst_db", db_stacks, '0);
`endif
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);

    // Push to full, then overflow
    for (int i = 0; i < DEPTH; i++) send(1, 0, 1'b1, 4'h0);
    send(1, 0, 1'b0, 4'h0);
    // Underflow on ch1, then clear it
    send(2, 1, 1'b0, 4'h0);
    send(6, 1, 1'b0, 4'h0);
    // LUT_POP (OR) and LUT (XOR) on ch0
    send(6, 0, 1'b0, 4'h0);
    send(1, 0, 1'b1, 4'h0);
    send(1, 0, 1'b0, 4'h0);
    send(5, 0, 1'b0, 4'b1110);
    send(4, 0, 1'b1, 4'b0110);
    send(5, 0, 1'b0, 4'b1110);
    send(7, 0, 1'b0, 4'h0);

    // Backpressure: hold rsp_ready low for 3 cycles
    set_ready(1'b1, 1'b1);
    set_ready(1'b1, 1'b1);
    set_ready(1'b1, 1'b0);
    send(1, 1, 1'b1, 4'h0);
    fork
      send(1, 1, 1'b0, 4'h0);
      begin
        @(negedge clk);
        chk("bp_cmd_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        rdy_val = 1'b1;
      end
    join
    send(3, 1, 1'b1, 4'h0);
    send(2, 1, 1'b0, 4'h0);
    set_ready(1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      send($urandom_range(0, 7), $urandom_range(0, NCH - 1),
           WIDTH'($urandom), 4'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset while a response is pending
    set_ready(1'b1, 1'b1);
    set_ready(1'b1, 1'b0);
    send(1, 0, 1'b1, 4'h0);
    chk("pre_rst_valid", rsp_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_depth", rsp_depth, '0);
    chk("mid_rst_top", rsp_top, '0);
    chk("mid_rst_sticky", err_sticky, '0);
`ifdef STACK_CALC_DBG_EN
    chk("mid_rst_db", db_stacks, '0);
`endif
    exp_q.delete();
    for (int c = 0; c < NCH; c++) stk[c].delete();
    m_sticky = '0;
    @(negedge clk); reset = 1'b1;
    set_ready(1'b0, 1'b0);
    for (int c = 0; c < NCH; c++) send(1, c, 1'b0, 4'h0);
    send(2, 0, 1'b0, 4'h0);
    send(2, 0, 1'b0, 4'h0);

    // Drain
    set_ready(1'b1, 1'b1);
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !rsp_valid) drained = 1'b1;
    end
    chk("drain", drained, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
